// File: rtl/seq_booth_multiplier_pkg.sv
// mult_pkg: shared definitions for seq_booth_multiplier
//   mult_state_t : IDLE (accepting operands), CALC (stepping), DONE (holding product)
//   cnt_width(w) : step-counter width, wide enough to count 0..w+1
package mult_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;
    function automatic int cnt_width(input int w);
        return $clog2(w + 2);
    endfunction
endpackage

// File: rtl/seq_booth_multiplier_booth_step.sv
// booth_step: one combinational radix-2 Booth step on {acc,Q,q_m1}
//   acc_i/acc_o   WIDTH+2  accumulator before/after add-and-shift
//   q_i/q_o       WIDTH+1  multiplier register before/after shift
//   q_m1_i/q_m1_o 1        Booth look-back bit before/after shift
//   m_i           WIDTH+1  extended multiplicand
module booth_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH+1:0] acc_i,
    input  logic [WIDTH:0]   q_i,
    input  logic             q_m1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH+1:0] acc_o,
    output logic [WIDTH:0]   q_o,
    output logic             q_m1_o
);
    logic [WIDTH+1:0] m_x;
    logic [WIDTH+1:0] sum;
    always_comb begin
        m_x    = {m_i[WIDTH], m_i};
        sum    = ({q_i[0], q_m1_i} == 2'b10) ? acc_i - m_x :
                 ({q_i[0], q_m1_i} == 2'b01) ? acc_i + m_x : acc_i;
        acc_o  = {sum[WIDTH+1], sum[WIDTH+1:1]};
        q_o    = {sum[0], q_i[WIDTH:1]};
        q_m1_o = q_i[0];
    end
endmodule

// File: rtl/seq_booth_multiplier.sv
// seq_booth_multiplier: iterative radix-2 Booth multiplier, one step per clock
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b[, is_signed])
//   a, b                WIDTH-bit multiplicand / multiplier
//   is_signed           only with MULT_UNSIGNED_SEL_EN: 1 = two's complement, 0 = unsigned
//   out_valid/out_ready product handshake; product held until consumed
//   product             full 2*WIDTH-bit result
//   busy                high while a job is in CALC or DONE
// Without MULT_UNSIGNED_SEL_EN operands are always two's complement.
import mult_pkg::*;
module seq_booth_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef MULT_UNSIGNED_SEL_EN
    input  logic               is_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    localparam int CW = cnt_width(WIDTH);
    mult_state_t        state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]     m_q, m_d, q_q, q_d, q_s;
    logic [WIDTH+1:0]   acc_q, acc_d, acc_s;
    logic               qm1_q, qm1_d, qm1_s, sgn;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               unused_acc;
`ifdef MULT_UNSIGNED_SEL_EN
    assign sgn = is_signed;
`else
    assign sgn = 1'b1;
`endif
    // the top acc bits only carry sign extension of the (WIDTH+1)x(WIDTH+1) product
    assign unused_acc = ^acc_q[WIDTH+1:WIDTH-1];
    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc_i(acc_q), .q_i(q_q), .q_m1_i(qm1_q), .m_i(m_q),
        .acc_o(acc_s), .q_o(q_s), .q_m1_o(qm1_s)
    );
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_d       = m_q;
        q_d       = q_q;
        acc_d     = acc_q;
        qm1_d     = qm1_q;
        product_d = product_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = CALC;
                m_d     = {sgn & a[WIDTH-1], a};
                q_d     = {sgn & b[WIDTH-1], b};
                acc_d   = '0;
                qm1_d   = 1'b0;
                cnt_d   = '0;
            end
            // WIDTH+1 steps, then one extra cycle to register the product
            CALC: if (cnt_q == CW'(WIDTH + 1)) begin
                state_d   = DONE;
                product_d = {acc_q[WIDTH-2:0], q_q};
            end else begin
                acc_d = acc_s;
                q_d   = q_s;
                qm1_d = qm1_s;
                cnt_d = cnt_q + 1'b1;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            m_q       <= '0;
            q_q       <= '0;
            acc_q     <= '0;
            qm1_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            m_q       <= m_d;
            q_q       <= q_d;
            acc_q     <= acc_d;
            qm1_q     <= qm1_d;
            product_q <= product_d;
        end
    end
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = product_q;
endmodule

// File: tb/tb_seq_booth_multiplier.sv
// tb_seq_booth_multiplier: scoreboard bench for seq_booth_multiplier (WIDTH=8)
module tb_seq_booth_multiplier;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        is_signed = 1'b1;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] product;
    logic        busy;
    int          cyc = 0;
    int          passed = 0;
    int          total = 0;
    bit          seen = 0;

    typedef struct {
        logic [15:0] p;
        int          acc_cyc;
    } exp_t;
    exp_t sb[$];

    seq_booth_multiplier #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
`ifdef MULT_UNSIGNED_SEL_EN
        .is_signed(is_signed),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) seen = 0;
        else if (out_valid) begin
            if (!seen) begin
                seen = 1;
                if (sb.size() == 0) check("spurious_output", out_valid, 0);
                else check("latency", cyc - sb[0].acc_cyc, 10);
            end
            if (out_ready) begin
                seen = 0;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("product", product, e.p);
                end
            end
        end
    end

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic s,
                         input logic [15:0] exp, input bit track);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        a = ia; b = ib; is_signed = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (track) sb.push_back('{exp, cyc});
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_product", product, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        issue(8'd3, 8'd5, 1, 16'h000F, 1);
        check("calc_busy", busy, 1);
        check("calc_in_ready", in_ready, 0);
        issue(8'h80, 8'h80, 1, 16'h4000, 1);
        issue(8'hFF, 8'h01, 1, 16'hFFFF, 1);
        issue(8'h00, 8'h7F, 1, 16'h0000, 1);
        issue(8'h7F, 8'h7F, 1, 16'h3F01, 1);
        issue(8'h80, 8'h7F, 1, 16'hC080, 1);
        issue(8'h7F, 8'h80, 1, 16'hC080, 1);
        issue(8'hFF, 8'hFF, 1, 16'h0001, 1);
        issue(8'h05, 8'hFB, 1, 16'hFFE7, 1);
        issue(8'h80, 8'h01, 1, 16'hFF80, 1);
        issue(8'h00, 8'h00, 1, 16'h0000, 1);
`ifdef MULT_UNSIGNED_SEL_EN
        issue(8'hFF, 8'hFF, 0, 16'hFE01, 1);
        issue(8'hFF, 8'hFF, 1, 16'h0001, 1);
        issue(8'h80, 8'h80, 0, 16'h4000, 1);
        issue(8'h7F, 8'h80, 0, 16'h3F80, 1);
`endif
        drain();
        out_ready = 1'b0;
        issue(8'h12, 8'h34, 1, 16'h03A8, 1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_valid_rise", out_valid, 1);
        repeat (6) begin
            check("bp_valid", out_valid, 1);
            check("bp_product", product, 16'h03A8);
            check("bp_in_ready", in_ready, 0);
            a = 8'h01; b = 8'h01; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        @(posedge clk); #1;
        check("after_bp_busy", busy, 0);
        check("after_bp_in_ready", in_ready, 1);
        issue(8'h05, 8'h07, 1, 16'h0023, 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_product", product, 0);
        rst = 1'b0;
        issue(8'hFE, 8'h03, 1, 16'hFFFA, 1);
        drain();
        repeat (20) @(posedge clk);
        #1;
        check("final_idle", out_valid, 0);
        check("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end
endmodule
